motoro3_pwm_multichannel: RTL and testbench
===========================================

# motoro3_pwm_multichannel

Parametrised N-channel PWM generator for the three-phase motor driver. It sits between the step sequencer, which supplies per-channel on-time requests, and the MOSFET gate drivers. Each channel runs off a shared period counter. Sub-minimum pulses are suppressed, their on-time is carried into later periods, and each channel keeps running want/real accounting. Edge-aligned and centre-aligned modes are supported.

## Interface
- NCH, default 3: number of PWM channels.
- CW, default 12: period/on-time counter width.
- PW, default 16: duty request and remainder width; PW >= CW.
- ACCW, default 24: want/real accumulator and lost-count width.
- clk  in  1  system clock, 10 MHz; all flops on falling edge.
- nRst  in  1  reset; nRst asynchronous, active-low.
- en  in  1  channel group active; low forces idle.
- sync  in  1  one-cycle pulse; restarts the period immediately.
- accClr  in  1  one-cycle pulse; clears want/real accumulators.
- periodLen  in  CW  period length in clocks; values < 2 are treated as 2.
- minPulse  in  CW  minimum allowed on-time in clocks.
- mode  in  1  0 = edge-aligned, 1 = centre-aligned.
- duty  in  NCH*PW  requested on-clocks per period; channel k is bits [k*PW +: PW].
- pwm  out  NCH  gate-drive outputs, registered.
- periodStart  out  1  high during the first clock of each period.
- lost  out  NCH*ACCW  signed wantAcc − realAcc per channel.

## Operation
- Shadowing: periodLen, minPulse, mode and duty are sampled only at a period start. Changes mid-period have no effect until the next start.
- Period counter pcnt runs 0 .. P−1, where P is the shadowed periodLen (clamped to ≥2), then wraps to 0.
- A period start occurs on any of these edges:
  - the wrap edge;
  - the first edge sampling en=1 after en=0 or after reset;
  - any edge sampling sync=1 while en=1.
- On-time decision per channel at each start:
  - eff = rem + duty[k], computed at PW+1 bits.
  - If eff >= minPulse and eff != 0: on = min(eff, P); rem <= eff − on, saturated to 2^PW−1.
  - Otherwise: on = 0; rem <= min(eff, 2^PW−1).
- Output condition:
  - Edge mode: pwm[k] = (pcnt < on).
  - Centre mode: s = (P − on) >> 1; pwm[k] = (s <= pcnt < s + on).
- Accounting:
  - wantAcc[k] += duty[k] at each start.
  - realAcc[k] += 1 for every clock with pwm[k]=1.
  - Both accumulators wrap modulo 2^ACCW.
  - lost is registered and updated every clock.
- accClr:
  - Zeroes wantAcc and realAcc.
  - If it coincides with a start, wantAcc loads duty[k] rather than 0.
  - If it coincides with pwm high, realAcc loads 0.
  - rem is not affected.
- en=0 (sampled):
  - Next edge sets pwm=0, pcnt=0, on=0 and rem=0.
  - No periodStart is generated.
  - Accumulators hold their values.
- sync while en=0 is ignored. sync coincident with a wrap produces a single start.

## Timing
- Reset values: pwm=0, periodStart=0, lost=0, pcnt=0, rem=0, on=0, accumulators=0.
- pwm and periodStart are registers. Their value in each clock equals the condition evaluated on that same clock's pcnt/on, so the implementation computes them from next-state values. There is no combinational path from any input to an output.
- The start edge sets pcnt=0, loads on, and raises periodStart. pwm in edge mode (on>0) is high in that same clock.
- A period lasts exactly P clocks. Restarts caused by sync truncate the current period.
- lost reflects the accumulator state one clock after the accumulators update.
- Asynchronous reset mid-operation takes effect immediately. The first start occurs on the first falling edge after release that samples en=1.

## Test plan
- Edge mode: NCH=3, periodLen=100, minPulse=32, duty={50,20,0}.
  - ch0 is high for pcnt 0–49 every period.
  - ch1 alternates 0 and 40 clocks per period.
  - ch2 is constantly low.
  - After 2 periods, ch1 lost = 0.
- Over-request: periodLen=100, duty=150.
  - pwm stays high continuously.
  - rem grows by 50 per period and saturates at 65535.
  - lost increases by 50 per period.
- Centre mode: periodLen=100, duty=40, minPulse=0.
  - pwm is high for pcnt 30–69.
  - periodStart pulses every 100 clocks.
- sync asserted at pcnt=37 with rem=10:
  - next clock has pcnt=0 and periodStart=1;
  - rem is preserved, so on = 10 + duty.
- en dropped at pcnt=20:
  - pwm goes 0 the next clock and rem=0.
  - Re-raising en gives periodStart on the first sampling edge, with on = duty.
- periodLen changed 100→60 mid-period:
  - the current period completes at 100;
  - the following period is 60 clocks.
- nRst pulsed mid-pulse: pwm drops to 0 asynchronously and lost reads 0.

Source files
------------

// File: rtl/motoro3_pwm_multichannel.sv
// N-channel PWM generator on a shared period counter with sub-minimum pulse
// suppression, on-time carry-over and per-channel want/real accounting.
module motoro3_pwm_multichannel #(
   parameter int NCH  = 3,
   parameter int CW   = 12,
   parameter int PW   = 16,
   parameter int ACCW = 24
) (
   input  logic                clk,
   input  logic                nRst,
   input  logic                en,
   input  logic                sync,
   input  logic                accClr,
   input  logic [CW-1:0]       periodLen,
   input  logic [CW-1:0]       minPulse,
   input  logic                mode,
   input  logic [NCH*PW-1:0]   duty,
   output logic [NCH-1:0]      pwm,
   output logic                periodStart,
   output logic [NCH*ACCW-1:0] lost
);

   localparam logic [CW-1:0] MIN_PER = CW'(2);

   logic                r_run;
   logic [CW-1:0]       r_pcnt;
   logic [CW-1:0]       r_per;
   logic [CW-1:0]       r_minp;
   logic                r_mode;
   logic [PW-1:0]       r_rem  [NCH];
   logic [CW-1:0]       r_on   [NCH];
   logic [ACCW-1:0]     r_want [NCH];
   logic [ACCW-1:0]     r_real [NCH];
   logic [NCH-1:0]      r_pwm;
   logic                r_ps;
   logic [NCH*ACCW-1:0] r_lost;

   logic                w_start;
   logic [CW-1:0]       w_per_n;
   logic [CW-1:0]       w_minp_n;
   logic [CW-1:0]       w_pcnt_n;
   logic                w_mode_n;
   logic [PW-1:0]       w_duty  [NCH];
   logic [CW-1:0]       w_on_n  [NCH];
   logic [PW-1:0]       w_rem_n [NCH];
   logic [NCH-1:0]      w_pwm_n;

   // A start is a wrap, a sync, or the first enabled edge after idle/reset.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_start  = en & (~r_run | sync | (r_pcnt == r_per - 1'b1));
      w_per_n  = r_per;
      w_minp_n = r_minp;
      w_mode_n = r_mode;
      w_pcnt_n = r_pcnt + 1'b1;
      if (w_start) begin
         w_per_n  = (periodLen < MIN_PER) ? MIN_PER : periodLen;
         w_minp_n = minPulse;
         w_mode_n = mode;
         w_pcnt_n = '0;
      end
   end

   always_comb begin : chan_next
      logic [PW:0]   v_eff;
      logic [PW:0]   v_left;
      logic [CW-1:0] v_s;
      logic [CW:0]   v_end;
      w_pwm_n = '0;
      for (int k = 0; k < NCH; k++) begin
         w_duty[k]  = duty[k*PW +: PW];
         v_eff      = {1'b0, r_rem[k]} + {1'b0, w_duty[k]};
         v_left     = '0;
         w_on_n[k]  = r_on[k];
         w_rem_n[k] = r_rem[k];
         if (w_start) begin
            if ((v_eff >= (PW+1)'(w_minp_n)) && (v_eff != '0)) begin
               w_on_n[k] = (v_eff > (PW+1)'(w_per_n)) ? w_per_n : v_eff[CW-1:0];
               v_left    = v_eff - (PW+1)'(w_on_n[k]);
            end else begin
               w_on_n[k] = '0;
               v_left    = v_eff;
            end
            w_rem_n[k] = v_left[PW] ? '1 : v_left[PW-1:0];
         end
         // Centre window is evaluated on next-state values so the register matches its clock.
         v_s   = (w_per_n - w_on_n[k]) >> 1;
         v_end = {1'b0, v_s} + {1'b0, w_on_n[k]};
         if (w_mode_n)
            w_pwm_n[k] = (w_pcnt_n >= v_s) && ({1'b0, w_pcnt_n} < v_end);
         else
            w_pwm_n[k] = (w_pcnt_n < w_on_n[k]);
      end
   end

   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         r_run  <= 1'b0;
         r_pcnt <= '0;
         r_per  <= MIN_PER;
         r_minp <= '0;
         r_mode <= 1'b0;
         r_pwm  <= '0;
         r_ps   <= 1'b0;
         r_lost <= '0;
         // NOTE: these per-channel arrays are plain flops, not RAM, so they are reset like any register.
         for (int k = 0; k < NCH; k++) begin
            r_rem[k]  <= '0;
            r_on[k]   <= '0;
            r_want[k] <= '0;
            r_real[k] <= '0;
         end
      end else begin
         if (!en) begin
            r_run  <= 1'b0;
            r_pcnt <= '0;
            r_pwm  <= '0;
            r_ps   <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
               r_rem[k] <= '0;
               r_on[k]  <= '0;
            end
         end else begin
            r_run  <= 1'b1;
            r_pcnt <= w_pcnt_n;
            r_per  <= w_per_n;
            r_minp <= w_minp_n;
            r_mode <= w_mode_n;
            r_pwm  <= w_pwm_n;
            r_ps   <= w_start;
            for (int k = 0; k < NCH; k++) begin
               r_rem[k] <= w_rem_n[k];
               r_on[k]  <= w_on_n[k];
            end
         end
         // realAcc counts the clock that just ended with the gate high.
         for (int k = 0; k < NCH; k++) begin
            r_lost[k*ACCW +: ACCW] <= r_want[k] - r_real[k];
            if (accClr) begin
               r_want[k] <= w_start ? ACCW'(w_duty[k]) : '0;
               r_real[k] <= '0;
            end else begin
               if (w_start)
                  r_want[k] <= r_want[k] + ACCW'(w_duty[k]);
               r_real[k] <= r_real[k] + ACCW'(r_pwm[k]);
            end
         end
      end
   end

   assign pwm         = r_pwm;
   assign periodStart = r_ps;
   assign lost        = r_lost;

endmodule

// File: tb/tb_motoro3_pwm_multichannel.sv
// Randomised and directed bench for motoro3_pwm_multichannel against a
// per-period behavioural model of the PWM rules.
module tb_motoro3_pwm_multichannel;

   localparam int NCH  = 3;
   localparam int CW   = 12;
   localparam int PW   = 16;
   localparam int ACCW = 24;
   localparam int MASK = 32'h00FF_FFFF;
   localparam int RMAX = 65535;

   logic                clk;
   logic                nRst;
   logic                en;
   logic                sync;
   logic                accClr;
   logic [CW-1:0]       periodLen;
   logic [CW-1:0]       minPulse;
   logic                mode;
   logic [NCH*PW-1:0]   duty;
   logic [NCH-1:0]      pwm;
   logic                periodStart;
   logic [NCH*ACCW-1:0] lost;

   int duty_a [NCH];
   int n_checks;
   int n_fail;

   // model state
   bit m_run, m_md, m_ps;
   int m_pcnt, m_P, m_mp;
   int m_on [NCH], m_rem [NCH], m_want [NCH], m_real [NCH], m_lost [NCH];
   bit m_pwm [NCH];

   motoro3_pwm_multichannel #(.NCH(NCH), .CW(CW), .PW(PW), .ACCW(ACCW)) dut (
      .clk(clk), .nRst(nRst), .en(en), .sync(sync), .accClr(accClr),
      .periodLen(periodLen), .minPulse(minPulse), .mode(mode), .duty(duty),
      .pwm(pwm), .periodStart(periodStart), .lost(lost)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   function automatic bit gate_of(int pc, int on, int per, bit md);
      int s;
      if (!md) return (pc < on);
      s = (per - on) / 2;
      return (pc >= s) && (pc < s + on);
   endfunction

   function automatic logic [NCH-1:0] m_pwm_vec();
      logic [NCH-1:0] v;
      for (int k = 0; k < NCH; k++) v[k] = m_pwm[k];
      return v;
   endfunction

   function automatic logic [NCH*ACCW-1:0] m_lost_vec();
      logic [NCH*ACCW-1:0] v;
      for (int k = 0; k < NCH; k++) v[k*ACCW +: ACCW] = m_lost[k][ACCW-1:0];
      return v;
   endfunction

   task automatic model_reset();
      m_run = 0; m_md = 0; m_ps = 0; m_pcnt = 0; m_P = 2; m_mp = 0;
      for (int k = 0; k < NCH; k++) begin
         m_on[k] = 0; m_rem[k] = 0; m_want[k] = 0; m_real[k] = 0; m_lost[k] = 0; m_pwm[k] = 0;
      end
   endtask

   // Applies the rules for one falling edge given the currently driven inputs.
   task automatic model_edge();
      bit start;
      int eff;
      start = 0;
      for (int k = 0; k < NCH; k++) m_lost[k] = (m_want[k] - m_real[k]) & MASK;
      if (!en) begin
         m_run = 0; m_pcnt = 0; m_ps = 0;
         for (int k = 0; k < NCH; k++) begin m_on[k] = 0; m_rem[k] = 0; end
      end else begin
         start = !m_run || sync || (m_pcnt == m_P - 1);
         m_run = 1;
         if (start) begin
            m_P = (int'(periodLen) < 2) ? 2 : int'(periodLen);
            m_mp = int'(minPulse);
            m_md = mode;
            m_pcnt = 0;
            for (int k = 0; k < NCH; k++) begin
               eff = m_rem[k] + duty_a[k];
               if (eff >= m_mp && eff != 0) begin
                  m_on[k] = (eff < m_P) ? eff : m_P;
                  m_rem[k] = (eff - m_on[k] > RMAX) ? RMAX : eff - m_on[k];
               end else begin
                  m_on[k] = 0;
                  m_rem[k] = (eff > RMAX) ? RMAX : eff;
               end
            end
         end else begin
            m_pcnt++;
         end
         m_ps = start;
      end
      for (int k = 0; k < NCH; k++) begin
         if (accClr) begin
            m_want[k] = start ? duty_a[k] : 0;
            m_real[k] = 0;
         end else begin
            if (start) m_want[k] = (m_want[k] + duty_a[k]) & MASK;
            m_real[k] = (m_real[k] + int'(m_pwm[k])) & MASK;
         end
         m_pwm[k] = en && gate_of(m_pcnt, m_on[k], m_P, m_md);
      end
   endtask

   task automatic step();
      for (int k = 0; k < NCH; k++) duty[k*PW +: PW] = duty_a[k][PW-1:0];
      model_edge();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      nRst = 1'b0; en = 1'b0; sync = 1'b0; accClr = 1'b0; mode = 1'b0;
      periodLen = 12'd100; minPulse = 12'd0;
      for (int k = 0; k < NCH; k++) duty_a[k] = 0;
      model_reset();
      #20;
      @(posedge clk);
      nRst = 1'b1;
   endtask

   task automatic test_reset();
      nRst = 1'b0; en = 1'b0; sync = 1'b0; accClr = 1'b0;
      #1;
      n_checks++; if (pwm !== '0) begin n_fail++; $display("FAIL reset_pwm got=%b want=0", pwm); end
      n_checks++; if (periodStart !== 1'b0) begin n_fail++; $display("FAIL reset_ps got=%b want=0", periodStart); end
      n_checks++; if (lost !== '0) begin n_fail++; $display("FAIL reset_lost got=%h want=0", lost); end
   endtask

   task automatic test_edge();
      bit exp0, exp1;
      do_reset();
      periodLen = 12'd100; minPulse = 12'd32; mode = 1'b0;
      duty_a[0] = 50; duty_a[1] = 20; duty_a[2] = 0;
      en = 1'b1;
      for (int i = 0; i < 400; i++) begin
         step();
         exp0 = (i % 100) < 50;
         exp1 = ((i / 100) % 2 == 1) && ((i % 100) < 40);
         n_checks++;
         if (pwm !== {1'b0, exp1, exp0} || pwm !== m_pwm_vec() || periodStart !== m_ps || lost !== m_lost_vec()) begin
            n_fail++;
            $display("FAIL edge i=%0d pwm=%b want=%b ps=%b want=%b lost=%h want=%h",
                     i, pwm, {1'b0, exp1, exp0}, periodStart, m_ps, lost, m_lost_vec());
         end
         if (i == 199) begin
            n_checks++;
            if (lost[ACCW +: ACCW] !== '0) begin n_fail++; $display("FAIL edge_lost_ch1 got=%0d want=0", lost[ACCW +: ACCW]); end
         end
      end
   endtask

   task automatic test_over_request();
      int prev;
      do_reset();
      periodLen = 12'd100; minPulse = 12'd0; mode = 1'b0;
      duty_a[0] = 150;
      en = 1'b1;
      prev = 0;
      for (int i = 0; i < 400; i++) begin
         step();
         n_checks++;
         if (pwm[0] !== 1'b1 || pwm !== m_pwm_vec() || lost !== m_lost_vec()) begin
            n_fail++; $display("FAIL over i=%0d pwm=%b want=%b lost=%h want=%h", i, pwm, m_pwm_vec(), lost, m_lost_vec());
         end
         if (i % 100 == 99) begin
            if (i > 99) begin
               n_checks++;
               if (int'(lost[ACCW-1:0]) - prev !== 50) begin
                  n_fail++; $display("FAIL over_lost_growth i=%0d got=%0d want=50", i, int'(lost[ACCW-1:0]) - prev);
               end
            end
            prev = int'(lost[ACCW-1:0]);
         end
      end
      // very short period makes the carry saturate within a couple of periods
      do_reset();
      periodLen = 12'd2; duty_a[0] = RMAX;
      en = 1'b1;
      for (int i = 0; i < 8; i++) step();
      n_checks++;
      if (dut.r_rem[0] !== 16'hFFFF || pwm[0] !== 1'b1) begin
         n_fail++; $display("FAIL rem_saturate got=%0d pwm=%b want=65535 pwm=1", dut.r_rem[0], pwm[0]);
      end
   endtask

   task automatic test_centre();
      bit exp;
      do_reset();
      periodLen = 12'd100; minPulse = 12'd0; mode = 1'b1;
      for (int k = 0; k < NCH; k++) duty_a[k] = 40;
      en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step();
         exp = ((i % 100) >= 30) && ((i % 100) < 70);
         n_checks++;
         if (pwm !== {NCH{exp}} || periodStart !== ((i % 100) == 0) || lost !== m_lost_vec()) begin
            n_fail++; $display("FAIL centre i=%0d pwm=%b want=%b ps=%b lost=%h want=%h",
                               i, pwm, {NCH{exp}}, periodStart, lost, m_lost_vec());
         end
      end
   endtask

   task automatic test_sync();
      int highs;
      do_reset();
      periodLen = 12'd100; minPulse = 12'd32; mode = 1'b0;
      duty_a[0] = 10;
      en = 1'b1;
      for (int i = 0; i <= 37; i++) step();
      sync = 1'b1; duty_a[0] = 30;
      step();
      sync = 1'b0;
      n_checks++;
      if (periodStart !== 1'b1 || dut.r_pcnt !== '0 || pwm[0] !== 1'b1) begin
         n_fail++; $display("FAIL sync_restart ps=%b pcnt=%0d pwm=%b want ps=1 pcnt=0 pwm=1", periodStart, dut.r_pcnt, pwm[0]);
      end
      highs = int'(pwm[0]);
      for (int i = 1; i < 100; i++) begin
         step();
         highs += int'(pwm[0]);
         n_checks++;
         if (pwm !== m_pwm_vec() || periodStart !== m_ps || lost !== m_lost_vec()) begin
            n_fail++; $display("FAIL sync_model i=%0d pwm=%b want=%b lost=%h want=%h", i, pwm, m_pwm_vec(), lost, m_lost_vec());
         end
      end
      n_checks++;
      if (highs !== 40) begin n_fail++; $display("FAIL sync_on_time got=%0d want=40", highs); end
   endtask

   task automatic test_en_drop();
      int highs;
      logic [NCH*ACCW-1:0] held;
      do_reset();
      periodLen = 12'd100; minPulse = 12'd0; mode = 1'b0;
      duty_a[0] = 150;
      en = 1'b1;
      for (int i = 0; i <= 20; i++) step();
      en = 1'b0;
      step();
      n_checks++;
      if (pwm !== '0 || periodStart !== 1'b0 || dut.r_rem[0] !== '0) begin
         n_fail++; $display("FAIL en_drop pwm=%b ps=%b rem=%0d want 0 0 0", pwm, periodStart, dut.r_rem[0]);
      end
      step();
      held = lost;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (lost !== held || lost !== m_lost_vec() || periodStart !== 1'b0) begin
            n_fail++; $display("FAIL en_hold i=%0d lost=%h want=%h ps=%b", i, lost, m_lost_vec(), periodStart);
         end
      end
      duty_a[0] = 30; en = 1'b1;
      step();
      n_checks++;
      if (periodStart !== 1'b1 || pwm[0] !== 1'b1) begin
         n_fail++; $display("FAIL en_restart ps=%b pwm=%b want 1 1", periodStart, pwm[0]);
      end
      highs = int'(pwm[0]);
      for (int i = 1; i < 100; i++) begin step(); highs += int'(pwm[0]); end
      n_checks++;
      if (highs !== 30) begin n_fail++; $display("FAIL en_restart_on got=%0d want=30", highs); end
   endtask

   task automatic test_period_change();
      bit exp;
      do_reset();
      periodLen = 12'd100; minPulse = 12'd0; mode = 1'b0;
      duty_a[0] = 50;
      en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step();
         if (i == 50) periodLen = 12'd60;
         exp = (i == 0) || (i == 100) || (i > 100 && ((i - 100) % 60) == 0);
         n_checks++;
         if (periodStart !== exp || pwm !== m_pwm_vec()) begin
            n_fail++; $display("FAIL period_change i=%0d ps=%b want=%b pwm=%b want=%b", i, periodStart, exp, pwm, m_pwm_vec());
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      periodLen = 12'd100; minPulse = 12'd0; mode = 1'b0;
      duty_a[0] = 50;
      en = 1'b1;
      for (int i = 0; i < 10; i++) step();
      #20;
      nRst = 1'b0;
      #1;
      n_checks++;
      if (pwm !== '0 || lost !== '0) begin
         n_fail++; $display("FAIL async_reset pwm=%b lost=%h want 0 0", pwm, lost);
      end
      model_reset();
      @(posedge clk);
      nRst = 1'b1;
      step();
      n_checks++;
      if (periodStart !== 1'b1 || pwm[0] !== 1'b1) begin
         n_fail++; $display("FAIL async_reset_restart ps=%b pwm=%b want 1 1", periodStart, pwm[0]);
      end
   endtask

   task automatic test_random();
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            periodLen = 12'($urandom_range(0, 20));
            minPulse  = 12'($urandom_range(0, 12));
            mode      = 1'($urandom_range(0, 1));
            for (int k = 0; k < NCH; k++) duty_a[k] = $urandom_range(0, 30);
         end
         sync   = ($urandom_range(0, 15) == 0);
         accClr = ($urandom_range(0, 15) == 0);
         en     = ($urandom_range(0, 31) != 0);
         step();
         n_checks++;
         if (pwm !== m_pwm_vec() || periodStart !== m_ps || lost !== m_lost_vec()) begin
            n_fail++; $display("FAIL random i=%0d pwm=%b want=%b ps=%b want=%b lost=%h want=%h",
                               i, pwm, m_pwm_vec(), periodStart, m_ps, lost, m_lost_vec());
         end
      end
      sync = 1'b0; accClr = 1'b0; en = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      periodLen = 12'd100; minPulse = 12'd0; mode = 1'b0; duty = '0;
      for (int k = 0; k < NCH; k++) duty_a[k] = 0;
      model_reset();
      test_reset();
      test_edge();
      test_over_request();
      test_centre();
      test_sync();
      test_en_drop();
      test_period_change();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
